// File: rtl/rsa_uart_wrapper.sv
// rsa_uart_wrapper: Avalon-MM master that pulls n, d and ciphertext bytes
// from the UART register window, runs the mod-exp core, and writes the
// result bytes back. The key is kept, so later blocks only send ciphertext.
// Optional block counter port blk_cnt is enabled by RSA_UART_BLOCK_CNT_EN.
module rsa_uart_wrapper #(
    parameter int KEY_BITS    = 256,
    parameter int RX_BASE     = 0,
    parameter int TX_BASE     = 4,
    parameter int STATUS_BASE = 8,
    parameter int RX_OK_BIT   = 7,
    parameter int TX_OK_BIT   = 6
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    output logic [4:0]          avm_address,
    output logic                avm_read,
    input  logic [31:0]         avm_readdata,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    output logic                core_start,
    output logic [KEY_BITS-1:0] core_a,
    output logic [KEY_BITS-1:0] core_d,
    output logic [KEY_BITS-1:0] core_n,
    input  logic [KEY_BITS-1:0] core_result,
    input  logic                core_finished
`ifdef RSA_UART_BLOCK_CNT_EN
    ,
    output logic [15:0]         blk_cnt
`endif
);

    localparam int BYTES = KEY_BITS / 8;
    localparam int CW    = $clog2(BYTES + 1);

    localparam logic [CW-1:0] CNT_RX_LAST = CW'(BYTES);
    localparam logic [CW-1:0] CNT_TX_LAST = CW'(BYTES - 1);

    localparam logic [4:0] A_RX     = 5'(RX_BASE);
    localparam logic [4:0] A_TX     = 5'(TX_BASE);
    localparam logic [4:0] A_STATUS = 5'(STATUS_BASE);

    localparam logic [2:0] S_QUERY_RX  = 3'd0;
    localparam logic [2:0] S_READ_RX   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_CORE = 3'd3;
    localparam logic [2:0] S_QUERY_TX  = 3'd4;
    localparam logic [2:0] S_WRITE_TX  = 3'd5;

    localparam logic [1:0] PH_N    = 2'd0;
    localparam logic [1:0] PH_D    = 2'd1;
    localparam logic [1:0] PH_DATA = 2'd2;

    logic [2:0]          state;
    logic [1:0]          phase;
    logic [CW-1:0]       cnt;
    logic [KEY_BITS-1:0] n_reg, d_reg, a_reg, res_reg;

    logic          done;
    logic [CW-1:0] cnt_nxt;
    logic [7:0]    rx_byte;
    logic          unused_rd;

    // A transfer finishes in the first cycle the slave stops stalling.
    assign done      = (avm_read | avm_write) & ~avm_waitrequest;
    assign cnt_nxt   = cnt + 1'b1;
    assign rx_byte   = avm_readdata[7:0];
    assign unused_rd = ^avm_readdata;

    assign core_a = a_reg;
    assign core_d = d_reg;
    assign core_n = n_reg;

    // Main sequencer: Avalon outputs only change on a completed transfer or
    // on a core event, so they stay put for the whole of any stall.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state         <= S_QUERY_RX;
            phase         <= PH_N;
            cnt           <= '0;
            n_reg         <= '0;
            d_reg         <= '0;
            a_reg         <= '0;
            res_reg       <= '0;
            avm_address   <= A_STATUS;
            avm_read      <= 1'b1;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            core_start    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                S_QUERY_RX: begin
                    // No RX byte yet: read stays high, re-issuing the poll.
                    if (done && avm_readdata[RX_OK_BIT]) begin
                        avm_address <= A_RX;
                        state       <= S_READ_RX;
                    end
                end
                S_READ_RX: begin
                    if (done) begin
                        case (phase)
                            PH_N:    n_reg <= {n_reg[KEY_BITS-9:0], rx_byte};
                            PH_D:    d_reg <= {d_reg[KEY_BITS-9:0], rx_byte};
                            default: a_reg <= {a_reg[KEY_BITS-9:0], rx_byte};
                        endcase
                        avm_address <= A_STATUS;
                        if (cnt_nxt == CNT_RX_LAST) begin
                            cnt <= '0;
                            case (phase)
                                PH_N: begin
                                    phase <= PH_D;
                                    state <= S_QUERY_RX;
                                end
                                PH_D: begin
                                    phase <= PH_DATA;
                                    state <= S_QUERY_RX;
                                end
                                default: begin
                                    // Operands are complete: pulse start while in S_START.
                                    avm_read   <= 1'b0;
                                    core_start <= 1'b1;
                                    state      <= S_START;
                                end
                            endcase
                        end else begin
                            cnt   <= cnt_nxt;
                            state <= S_QUERY_RX;
                        end
                    end
                end
                S_START: begin
                    avm_read <= 1'b0;
                    state    <= S_WAIT_CORE;
                end
                S_WAIT_CORE: begin
                    if (core_finished) begin
                        res_reg     <= core_result;
                        avm_read    <= 1'b1;
                        avm_address <= A_STATUS;
                        state       <= S_QUERY_TX;
                    end
                end
                S_QUERY_TX: begin
                    if (done && avm_readdata[TX_OK_BIT]) begin
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b1;
                        avm_address   <= A_TX;
                        // Top result byte is never sent; next byte down goes first.
                        avm_writedata <= {24'b0, res_reg[KEY_BITS-9 -: 8]};
                        state         <= S_WRITE_TX;
                    end
                end
                S_WRITE_TX: begin
                    if (done) begin
                        res_reg       <= res_reg << 8;
                        avm_write     <= 1'b0;
                        avm_writedata <= '0;
                        avm_read      <= 1'b1;
                        avm_address   <= A_STATUS;
                        if (cnt_nxt == CNT_TX_LAST) begin
                            cnt   <= '0;
                            phase <= PH_DATA;
                            state <= S_QUERY_RX;
                        end else begin
                            cnt   <= cnt_nxt;
                            state <= S_QUERY_TX;
                        end
                    end
                end
                default: state <= S_QUERY_RX;
            endcase
        end
    end

`ifdef RSA_UART_BLOCK_CNT_EN
    // Blocks fully sent: steps on the final TX write completion, wraps at 16 bits.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst)
            blk_cnt <= '0;
        else if (state == S_WRITE_TX && done && cnt_nxt == CNT_TX_LAST)
            blk_cnt <= blk_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rsa_uart_wrapper.sv
// Bench for rsa_uart_wrapper at KEY_BITS=16: a UART register-window model
// with programmable stalls and poll delays, plus a mod-exp core model.
// Expected plaintext bytes are hand-computed constants (n=3233, d=2753).
module tb_rsa_uart_wrapper;

    localparam int KB = 16;

    logic          avm_clk = 1'b0;
    logic          avm_rst;
    logic [4:0]    avm_address;
    logic          avm_read;
    logic [31:0]   avm_readdata;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest;
    logic          core_start;
    logic [KB-1:0] core_a, core_d, core_n, core_result;
    logic          core_finished;
`ifdef RSA_UART_BLOCK_CNT_EN
    logic [15:0]   blk_cnt;
`endif

    rsa_uart_wrapper #(.KEY_BITS(KB)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .core_start(core_start), .core_a(core_a), .core_d(core_d), .core_n(core_n),
        .core_result(core_result), .core_finished(core_finished)
`ifdef RSA_UART_BLOCK_CNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    always #5 avm_clk = ~avm_clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [KB-1:0] modexp(input logic [KB-1:0] a, d, n);
        logic [63:0] r, b;
        r = 64'd1;
        b = 64'(a) % 64'(n);
        for (int i = KB - 1; i >= 0; i--) begin
            r = (r * r) % 64'(n);
            if (d[i]) r = (r * b) % 64'(n);
        end
        return r[KB-1:0];
    endfunction

    // UART window model state
    logic [7:0]  rx_q[$];
    logic [31:0] tx_q[$];
    int wait_n = 0, rx_poll = 0, tx_poll = 0;
    int rx_hold = 0, tx_hold = 0, wctr = 0;
    int held_viol = 0, rx_bad = 0, tx_bad = 0, bad_addr = 0, rw_both = 0;
    logic prev_wr = 1'b0;
    logic [38:0] snap;
    // core model state
    int start_cnt = 0, lat = 0;
    logic fin_m = 1'b0, spur = 1'b0;

    assign core_finished = fin_m | spur;

    // Slave and core models decide at negedge what the DUT sees at the next posedge.
    always @(negedge avm_clk) begin
        logic rx_ok, tx_ok;
        if (avm_rst) begin
            avm_waitrequest = 1'b0;
            avm_readdata    = 32'h0;
            wctr = 0; prev_wr = 1'b0; lat = 0; fin_m = 1'b0;
        end else begin
            if (prev_wr && {avm_address, avm_read, avm_write, avm_writedata} !== snap)
                held_viol++;
            snap = {avm_address, avm_read, avm_write, avm_writedata};
            if (avm_read && avm_write) rw_both++;
            avm_waitrequest = 1'b0;
            if (avm_read || avm_write) begin
                if (wctr < wait_n) begin
                    avm_waitrequest = 1'b1;
                    wctr++;
                end else begin
                    wctr = 0;
                    if (avm_read && avm_address == 5'd8) begin
                        rx_ok = (rx_q.size() > 0) && (rx_hold == 0);
                        tx_ok = (tx_hold == 0);
                        avm_readdata = {24'h0, rx_ok, tx_ok, 6'b000101};
                        if (rx_q.size() > 0 && rx_hold > 0) rx_hold--;
                        if (tx_hold > 0) tx_hold--;
                    end else if (avm_read && avm_address == 5'd0) begin
                        if (rx_q.size() == 0 || rx_hold != 0) begin
                            rx_bad++;
                            avm_readdata = 32'hDEAD_BEEF;
                        end else begin
                            avm_readdata = {24'h5A5A5A, rx_q.pop_front()};
                            rx_hold = rx_poll;
                        end
                    end else if (avm_write && avm_address == 5'd4) begin
                        if (tx_hold != 0) tx_bad++;
                        tx_q.push_back(avm_writedata);
                        tx_hold = tx_poll;
                    end else begin
                        bad_addr++;
                    end
                end
            end
            prev_wr = avm_waitrequest;
            fin_m = 1'b0;
            if (core_start) begin
                start_cnt++;
                core_result = modexp(core_a, core_d, core_n);
                lat = 4;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    fin_m   = 1'b1;
                    tx_hold = tx_poll;
                end
            end
        end
    end

    typedef struct {
        int         nb;
        logic [7:0] b[6];
        int         wait_n;
        int         rx_poll;
        int         tx_poll;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 5;
    vec_t tbl[NV];

    task automatic run_vec(input vec_t v, input string tag);
        int s0, cyc;
        @(negedge avm_clk);
        wait_n = v.wait_n; rx_poll = v.rx_poll; tx_poll = v.tx_poll;
        rx_hold = v.rx_poll;
        tx_q.delete();
        held_viol = 0; rx_bad = 0; tx_bad = 0;
        s0 = start_cnt;
        for (int j = 0; j < v.nb; j++) rx_q.push_back(v.b[j]);
        cyc = 0;
        while (tx_q.size() < 1 && cyc < 5000) begin
            @(negedge avm_clk);
            cyc++;
        end
        repeat (40) @(negedge avm_clk);
        chk({tag, " tx_count"}, 64'(tx_q.size()), 64'd1);
        chk({tag, " tx_data"}, (tx_q.size() > 0) ? 64'(tx_q[0]) : 64'hFFFF_FFFF, {56'h0, v.exp});
        chk({tag, " rx_left"}, 64'(rx_q.size()), 64'd0);
        chk({tag, " starts"}, 64'(start_cnt - s0), 64'd1);
        chk({tag, " held"}, 64'(held_viol), 64'd0);
        chk({tag, " rx_tx_early"}, 64'(rx_bad + tx_bad), 64'd0);
        chk({tag, " key_n_d"}, {32'h0, core_n, core_d}, {32'h0, 16'h0CA1, 16'h0AC1});
        chk({tag, " core_a"}, 64'(core_a), {48'h0, v.b[v.nb-2], v.b[v.nb-1]});
        chk({tag, " idle_poll"}, {57'h0, avm_read, avm_write, avm_address}, {57'h0, 1'b1, 1'b0, 5'd8});
    endtask

    initial begin
        int s0, cyc;
        // full key + c=2790 -> 65; c=0x0B5C (2908) -> 0x0C5B, low byte 0x5B
        tbl[0] = '{nb: 6, b: '{8'h0C, 8'hA1, 8'h0A, 8'hC1, 8'h0A, 8'hE6}, wait_n: 0, rx_poll: 0,  tx_poll: 0, exp: 8'h41};
        tbl[1] = '{nb: 2, b: '{8'h0B, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00}, wait_n: 0, rx_poll: 0,  tx_poll: 0, exp: 8'h5B};
        tbl[2] = '{nb: 2, b: '{8'h0A, 8'hE6, 8'h00, 8'h00, 8'h00, 8'h00}, wait_n: 5, rx_poll: 0,  tx_poll: 0, exp: 8'h41};
        tbl[3] = '{nb: 2, b: '{8'h0B, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00}, wait_n: 0, rx_poll: 10, tx_poll: 7, exp: 8'h5B};
        tbl[4] = '{nb: 2, b: '{8'h0A, 8'hE6, 8'h00, 8'h00, 8'h00, 8'h00}, wait_n: 5, rx_poll: 3,  tx_poll: 2, exp: 8'h41};

        avm_rst = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0;
        core_result = '0;
        repeat (3) @(negedge avm_clk);
        chk("rst avm_ctl", {57'h0, avm_read, avm_write, avm_address}, {57'h0, 1'b1, 1'b0, 5'd8});
        chk("rst writedata", 64'(avm_writedata), 64'd0);
        chk("rst core_start", 64'(core_start), 64'd0);
        chk("rst core_n_d_a", {16'h0, core_n, core_d, core_a}, 64'd0);
        avm_rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
`ifdef RSA_UART_BLOCK_CNT_EN
        chk("blk_cnt after vectors", 64'(blk_cnt), 64'(NV));
`endif

        // Spurious core_finished while idle in the RX poll loop.
        wait_n = 0; rx_poll = 0; tx_poll = 0;
        tx_q.delete();
        s0 = start_cnt;
        @(negedge avm_clk) spur = 1'b1;
        @(negedge avm_clk) spur = 1'b0;
        repeat (40) @(negedge avm_clk);
        chk("spur no_tx", 64'(tx_q.size()), 64'd0);
        chk("spur no_start", 64'(start_cnt - s0), 64'd0);
        chk("spur idle_poll", {57'h0, avm_read, avm_write, avm_address}, {57'h0, 1'b1, 1'b0, 5'd8});

        // Reset after 3 of 6 key bytes, then resend everything.
        for (int j = 0; j < 6; j++) rx_q.push_back(tbl[0].b[j]);
        cyc = 0;
        while (rx_q.size() > 3 && cyc < 1000) begin
            @(negedge avm_clk);
            cyc++;
        end
        chk("midrst reached", 64'(rx_q.size()), 64'd3);
        avm_rst = 1'b1;
        rx_q.delete();
        @(negedge avm_clk);
        chk("midrst avm_ctl", {57'h0, avm_read, avm_write, avm_address}, {57'h0, 1'b1, 1'b0, 5'd8});
        chk("midrst core_n_d_a", {16'h0, core_n, core_d, core_a}, 64'd0);
        chk("midrst core_start", 64'(core_start), 64'd0);
        @(negedge avm_clk) avm_rst = 1'b0;
        run_vec(tbl[0], "resend");
        run_vec(tbl[1], "resend_blk2");
`ifdef RSA_UART_BLOCK_CNT_EN
        chk("blk_cnt after reset", 64'(blk_cnt), 64'd2);
`endif
        chk("read_write_together", 64'(rw_both), 64'd0);
        chk("bad_address", 64'(bad_addr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rsa_uart_wrapper.md
Name: rsa_uart_wrapper

Overview:
- Avalon-MM master that drives the UART register window and feeds a modular-exponentiation core through a start/finished handshake.
- Successor to the fixed 256-bit wrapper:
  - key width is parametrised;
  - every Avalon access honours avm_waitrequest;
  - each RX byte is gated by its own RX_OK poll;
  - the key is retained, so multiple ciphertext blocks are decrypted without reloading n/d.
- Sits between the UART IP and the exponentiation core at the top level of the lab design.

Parameters:
- KEY_BITS, 256, operand width of n, d, ciphertext and result; multiple of 8, minimum 16.
- RX_BASE, 0, UART RX data register byte address.
- TX_BASE, 4, UART TX data register byte address.
- STATUS_BASE, 8, UART status register byte address.
- RX_OK_BIT, 7, status bit: RX byte available.
- TX_OK_BIT, 6, status bit: TX ready.

Ports:
- avm_clk  in  1  clock.
- avm_rst  in  1  asynchronous active-high reset.
- avm_address  out  5  Avalon address.
- avm_read  out  1  Avalon read request.
- avm_readdata  in  32  Avalon read data.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  Avalon write data: {24'b0, byte}.
- avm_waitrequest  in  1  Avalon stall.
- core_start  out  1  one-cycle start pulse to core.
- core_a  out  KEY_BITS  ciphertext.
- core_d  out  KEY_BITS  private exponent.
- core_n  out  KEY_BITS  modulus.
- core_result  in  KEY_BITS  a^d mod n.
- core_finished  in  1  result valid (pulse).

Behaviour:
- BYTES = KEY_BITS/8. Phase register takes values PH_N, PH_D, PH_DATA. Byte counter is $clog2(BYTES+1) bits.
- Reset values:
  - avm_read=1, avm_address=STATUS_BASE, avm_write=0, avm_writedata=0;
  - core_start=0;
  - n, d, a and result registers all 0;
  - state=S_QUERY_RX, phase=PH_N, counter=0.
- Avalon rule: address, read, write and writedata are registered and held unchanged while avm_waitrequest=1. A transfer completes in the first cycle with avm_waitrequest=0; readdata is sampled only in that cycle.
- States:
  - S_QUERY_RX: read STATUS_BASE.
    - On completion with bit RX_OK_BIT=1: next access is read RX_BASE, go to S_READ_RX.
    - Otherwise: re-issue the status read.
  - S_READ_RX: on completion, shift readdata[7:0] into the LSB of the phase's register (MSB first on the wire), counter+1.
    - Counter reaching BYTES: clear counter and advance the phase. PH_N goes to PH_D. PH_D goes to PH_DATA. PH_DATA goes to S_START.
    - All other cases: return to S_QUERY_RX.
  - S_START: deassert read; core_start=1 for exactly one cycle; go to S_WAIT_CORE.
  - S_WAIT_CORE: no Avalon access (read=write=0). On core_finished, latch core_result into the shift register, then go to S_QUERY_TX with a status read issued.
  - S_QUERY_TX: on completion with TX_OK_BIT=1, issue write TX_BASE and go to S_WRITE_TX. Else re-poll.
  - S_WRITE_TX:
    - writedata = bits [KEY_BITS-9 -: 8] of the shift register, so the top byte is discarded; BYTES-1 bytes are sent MSB first.
    - On completion: shift left 8, counter+1.
    - Counter reaching BYTES-1: clear counter, phase=PH_DATA, go to S_QUERY_RX. Otherwise go to S_QUERY_TX.
- Key is retained across blocks. The only way back to PH_N is reset.
- core_a/d/n are stable from core_start until the next PH_DATA byte is received.
- core_finished outside S_WAIT_CORE is ignored.
- Reset mid-operation: all partial key/data is discarded; the block restarts in PH_N.
- Read and write are never asserted together.

Optional Feature:
- Macro RSA_UART_BLOCK_CNT_EN.
- Defined:
  - adds port blk_cnt out 16: count of fully transmitted blocks;
  - the count increments in the cycle the last TX byte completes, wraps 0xFFFF to 0, and resets to 0.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- KEY_BITS=16, UART model supplies bytes 0C A1 0A C1 0A E6 (n=3233, d=2753, c=2790); core model computes a^d mod n → exactly one TX write, writedata=0x00000041; FSM returns to S_QUERY_RX in PH_DATA.
- Same key, second ciphertext 0x0B5C → TX 0xXX only after the next 2 RX bytes; n/d are not re-read; core_start pulses once per block.
- avm_waitrequest held high for 5 cycles on every access → address/read/write held constant; each byte is captured only once; result is unchanged versus zero-wait.
- Status RX_OK=0 for 10 polls between bytes, TX_OK=0 for 7 polls → no RX/TX access until the bit is set; byte order is preserved.
- avm_rst asserted after 3 of 6 key bytes → outputs return to reset values immediately; a full resend of 6 bytes decrypts correctly.
- With RSA_UART_BLOCK_CNT_EN, 3 blocks at KEY_BITS=256 → blk_cnt=3, each step on the last TX completion; spurious core_finished during S_QUERY_RX has no effect.
